// File: rtl/svk_axi_pkg.sv
// svk_axi_pkg: shared AXI response codes and round-robin pick helper for the SVK fabric
package svk_axi_pkg;
  localparam logic [1:0] SVK_AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] SVK_AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] SVK_AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] SVK_AXI_RESP_DECERR = 2'b11;
  // Scans downward so the last hit is the first requester at or after ptr; returns ptr when idle.
  function automatic logic [3:0] svk_rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    logic [3:0] r;
    logic [3:0] k;
    r = ptr;
    for (int i = 15; i >= 0; i--) begin
      k = 4'((int'(ptr) + i) % n);
      if (i < n && req[k]) r = k;
    end
    return r;
  endfunction
endpackage

// File: rtl/svk_axi_ord_fifo.sv
// svk_axi_ord_fifo: synchronous FIFO holding AW grant order for W steering
module svk_axi_ord_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign head = mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/svk_axi_wr_arb.sv
// svk_axi_wr_arb: N-master to 1-slave AXI write arbiter with in-order W steering and B routing
module svk_axi_wr_arb
  import svk_axi_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int ID_W = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 8,
  parameter int ORD_DEPTH = 4,
  localparam int MST_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
  localparam int S_ID_W = ID_W + MST_W
) (
  input  logic                      aclk,
  input  logic                      reset,
  input  logic [NUM_MST-1:0]        m_awvalid,
  output logic [NUM_MST-1:0]        m_awready,
  input  logic [NUM_MST*ID_W-1:0]   m_awid,
  input  logic [NUM_MST*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_MST*LEN_W-1:0]  m_awlen,
  input  logic [NUM_MST-1:0]        m_wvalid,
  output logic [NUM_MST-1:0]        m_wready,
  input  logic [NUM_MST*DATA_W-1:0] m_wdata,
  input  logic [NUM_MST-1:0]        m_wlast,
  output logic [NUM_MST-1:0]        m_bvalid,
  input  logic [NUM_MST-1:0]        m_bready,
  output logic [ID_W-1:0]           m_bid,
  output logic [1:0]                m_bresp,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [S_ID_W-1:0]         s_awid,
  output logic [ADDR_W-1:0]         s_awaddr,
  output logic [LEN_W-1:0]          s_awlen,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  output logic [DATA_W-1:0]         s_wdata,
  output logic                      s_wlast,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  input  logic [S_ID_W-1:0]         s_bid,
  input  logic [1:0]                s_bresp,
  output logic                      err_bad_bid
);
  logic live, en, hold, full, empty, push, pop, bad;
  logic [MST_W-1:0] rr_ptr, gnt_idx, pick, cur, head, bidx;
  // live stays low through the first cycle after reset so every handshake output starts quiet.
  assign en = live && !reset;
  assign pick = MST_W'(svk_rr_pick(16'(m_awvalid), 4'(rr_ptr), NUM_MST));
  assign cur = hold ? gnt_idx : pick;
  assign s_awvalid = en && !full && m_awvalid[cur];
  assign m_awready = (en && !full) ? NUM_MST'(s_awready) << cur : '0;
  assign s_awid = {cur, m_awid[cur*ID_W +: ID_W]};
  assign s_awaddr = m_awaddr[cur*ADDR_W +: ADDR_W];
  assign s_awlen = m_awlen[cur*LEN_W +: LEN_W];
  assign push = s_awvalid && s_awready;
  assign s_wvalid = en && !empty && m_wvalid[head];
  assign m_wready = (en && !empty) ? NUM_MST'(s_wready) << head : '0;
  assign s_wdata = m_wdata[head*DATA_W +: DATA_W];
  assign s_wlast = m_wlast[head];
  assign pop = s_wvalid && s_wready && s_wlast;
  assign bidx = s_bid[S_ID_W-1 -: MST_W];
  assign bad = int'(bidx) >= NUM_MST;
  assign m_bvalid = (en && s_bvalid && !bad) ? NUM_MST'(1) << bidx : '0;
  assign s_bready = en && (bad || m_bready[bidx]);
  assign err_bad_bid = en && s_bvalid && bad;
  assign m_bid = s_bid[ID_W-1:0];
  assign m_bresp = s_bresp;
  always_ff @(posedge aclk) begin
    if (reset) begin
      live <= 1'b0;
      hold <= 1'b0;
      rr_ptr <= '0;
      gnt_idx <= '0;
    end else begin
      live <= 1'b1;
      if (push) begin
        hold <= 1'b0;
        rr_ptr <= (cur == MST_W'(NUM_MST - 1)) ? '0 : cur + 1'b1;
      end else if (s_awvalid && !s_awready) begin
        hold <= 1'b1;
        gnt_idx <= cur;
      end
    end
  end
  svk_axi_ord_fifo #(.WIDTH(MST_W), .DEPTH(ORD_DEPTH)) u_ord (
    .clk(aclk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din(cur),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule
